// File: rtl/riscv_axi_arb_pkg.sv
// Shared state encodings and port indices for the two-to-one AXI arbiter.
package riscv_axi_arb_pkg;
   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/riscv_axi_arb_if.sv
// One AXI4 port bundle; master drives requests, slave drives ready/response.
interface riscv_axi_arb_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              awvalid, awready;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0]   awid;
   logic [7:0]        awlen;
   logic [1:0]        awburst;
   logic              wvalid, wready, wlast;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic              bvalid, bready;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              arvalid, arready;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic [7:0]        arlen;
   logic [1:0]        arburst;
   logic              rvalid, rready, rlast;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic [ID_W-1:0]   rid;

   modport master (
      output awvalid, awaddr, awid, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arid, arlen, arburst, rready,
      input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
   );
   modport slave (
      input  awvalid, awaddr, awid, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arid, arlen, arburst, rready,
      output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
   );
endinterface

// File: rtl/riscv_axi_arb_gnt.sv
// Two-request grant picker: fixed dcache priority, or round-robin when RISCV_AXI_ARB_RR_EN is defined.
module riscv_axi_arb_gnt
   import riscv_axi_arb_pkg::*;
(
`ifdef RISCV_AXI_ARB_RR_EN
   input  logic       clk,
   input  logic       rst_n,
   input  logic       take,
`endif
   input  logic [1:0] req,
   output logic       gnt
);
`ifdef RISCV_AXI_ARB_RR_EN
   logic last;

   // On a tie the port not granted last wins; otherwise the lone requester.
   assign gnt = (req == 2'b11) ? ~last : req[PORT_D];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= PORT_I;
      end else if (take) begin
         last <= gnt;
      end
   end
`else
   assign gnt = req[PORT_D] | ~req[PORT_I];
`endif
endmodule

// File: rtl/riscv_axi_arb.sv
// Merges icache (s0) and dcache (s1) AXI4 masters; AR/AW one cycle after request, R/W/B pass through.
// One burst outstanding per path; non-granted ports see no ready/valid. Tie policy: RISCV_AXI_ARB_RR_EN.
module riscv_axi_arb
   import riscv_axi_arb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   riscv_axi_arb_if.slave  s0,
   riscv_axi_arb_if.slave  s1,
   riscv_axi_arb_if.master m
);
   rd_state_t rd_state;
   wr_state_t wr_state;
   logic      rd_gnt, wr_gnt, rd_pick, wr_pick;
   logic      aw_done, w_done, aw_hs, wl_hs;
   logic      ra0, ra1, rd0, rd1, aw0, aw1, wv0, wv1, wr0, wr1;

`ifdef RISCV_AXI_ARB_RR_EN
   logic rd_take, wr_take;
   assign rd_take = (rd_state == RD_IDLE) && (s0.arvalid || s1.arvalid);
   assign wr_take = (wr_state == WR_IDLE) && (s0.awvalid || s1.awvalid);
`endif

   riscv_axi_arb_gnt u_rd_gnt (
`ifdef RISCV_AXI_ARB_RR_EN
      .clk(clk), .rst_n(rst_n), .take(rd_take),
`endif
      .req({s1.arvalid, s0.arvalid}), .gnt(rd_pick)
   );

   riscv_axi_arb_gnt u_wr_gnt (
`ifdef RISCV_AXI_ARB_RR_EN
      .clk(clk), .rst_n(rst_n), .take(wr_take),
`endif
      .req({s1.awvalid, s0.awvalid}), .gnt(wr_pick)
   );

   // Phase-and-owner qualifiers; every routed signal is gated by one of these.
   assign ra0 = (rd_state == RD_ADDR) && (rd_gnt == PORT_I);
   assign ra1 = (rd_state == RD_ADDR) && (rd_gnt == PORT_D);
   assign rd0 = (rd_state == RD_DATA) && (rd_gnt == PORT_I);
   assign rd1 = (rd_state == RD_DATA) && (rd_gnt == PORT_D);
   assign aw0 = (wr_state == WR_XFER) && !aw_done && (wr_gnt == PORT_I);
   assign aw1 = (wr_state == WR_XFER) && !aw_done && (wr_gnt == PORT_D);
   assign wv0 = (wr_state == WR_XFER) && !w_done && (wr_gnt == PORT_I);
   assign wv1 = (wr_state == WR_XFER) && !w_done && (wr_gnt == PORT_D);
   assign wr0 = (wr_state == WR_RESP) && (wr_gnt == PORT_I);
   assign wr1 = (wr_state == WR_RESP) && (wr_gnt == PORT_D);

   assign m.arvalid  = (ra0 && s0.arvalid) || (ra1 && s1.arvalid);
   assign m.araddr   = ra1 ? s1.araddr  : ra0 ? s0.araddr  : '0;
   assign m.arid     = ra1 ? s1.arid    : ra0 ? s0.arid    : '0;
   assign m.arlen    = ra1 ? s1.arlen   : ra0 ? s0.arlen   : '0;
   assign m.arburst  = ra1 ? s1.arburst : ra0 ? s0.arburst : '0;
   assign s0.arready = ra0 && m.arready;
   assign s1.arready = ra1 && m.arready;

   assign m.rready   = (rd0 && s0.rready) || (rd1 && s1.rready);
   assign s0.rvalid  = rd0 && m.rvalid;
   assign s1.rvalid  = rd1 && m.rvalid;
   assign s0.rdata   = rd0 ? m.rdata : '0;
   assign s1.rdata   = rd1 ? m.rdata : '0;
   assign s0.rresp   = rd0 ? m.rresp : '0;
   assign s1.rresp   = rd1 ? m.rresp : '0;
   assign s0.rid     = rd0 ? m.rid   : '0;
   assign s1.rid     = rd1 ? m.rid   : '0;
   assign s0.rlast   = rd0 && m.rlast;
   assign s1.rlast   = rd1 && m.rlast;

   assign m.awvalid  = (aw0 && s0.awvalid) || (aw1 && s1.awvalid);
   assign m.awaddr   = aw1 ? s1.awaddr  : aw0 ? s0.awaddr  : '0;
   assign m.awid     = aw1 ? s1.awid    : aw0 ? s0.awid    : '0;
   assign m.awlen    = aw1 ? s1.awlen   : aw0 ? s0.awlen   : '0;
   assign m.awburst  = aw1 ? s1.awburst : aw0 ? s0.awburst : '0;
   assign s0.awready = aw0 && m.awready;
   assign s1.awready = aw1 && m.awready;

   assign m.wvalid   = (wv0 && s0.wvalid) || (wv1 && s1.wvalid);
   assign m.wdata    = wv1 ? s1.wdata : wv0 ? s0.wdata : '0;
   assign m.wstrb    = wv1 ? s1.wstrb : wv0 ? s0.wstrb : '0;
   assign m.wlast    = (wv0 && s0.wlast) || (wv1 && s1.wlast);
   assign s0.wready  = wv0 && m.wready;
   assign s1.wready  = wv1 && m.wready;

   assign m.bready   = (wr0 && s0.bready) || (wr1 && s1.bready);
   assign s0.bvalid  = wr0 && m.bvalid;
   assign s1.bvalid  = wr1 && m.bvalid;
   assign s0.bresp   = wr0 ? m.bresp : '0;
   assign s1.bresp   = wr1 ? m.bresp : '0;
   assign s0.bid     = wr0 ? m.bid   : '0;
   assign s1.bid     = wr1 ? m.bid   : '0;

   assign aw_hs = m.awvalid && m.awready;
   assign wl_hs = m.wvalid && m.wready && m.wlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         rd_gnt   <= PORT_I;
      end else begin
         case (rd_state)
            RD_IDLE: if (s0.arvalid || s1.arvalid) begin
               rd_gnt   <= rd_pick;
               rd_state <= RD_ADDR;
            end
            RD_ADDR: if (m.arvalid && m.arready) rd_state <= RD_DATA;
            RD_DATA: if (m.rvalid && m.rready && m.rlast) rd_state <= RD_IDLE;
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // W may finish before AW; w_done stops further W forwarding until AW lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= WR_IDLE;
         wr_gnt   <= PORT_I;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (wr_state)
            WR_IDLE: if (s0.awvalid || s1.awvalid) begin
               wr_gnt   <= wr_pick;
               aw_done  <= 1'b0;
               w_done   <= 1'b0;
               wr_state <= WR_XFER;
            end
            WR_XFER: begin
               if (aw_hs) aw_done <= 1'b1;
               if (wl_hs) w_done <= 1'b1;
               if ((aw_done || aw_hs) && (w_done || wl_hs)) wr_state <= WR_RESP;
            end
            WR_RESP: if (m.bvalid && m.bready) wr_state <= WR_IDLE;
            default: wr_state <= WR_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_axi_arb.sv
// Directed self-checking bench for riscv_axi_arb (tie expectations follow RISCV_AXI_ARB_RR_EN).
module tb_riscv_axi_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   riscv_axi_arb_if s0_if ();
   riscv_axi_arb_if s1_if ();
   riscv_axi_arb_if m_if ();

   riscv_axi_arb dut (.clk(clk), .rst_n(rst_n), .s0(s0_if), .s1(s1_if), .m(m_if));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] hs_outs();
      return {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
              s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
              s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid};
   endfunction

   task automatic clear_inputs();
      s0_if.awvalid = 0; s0_if.awaddr = 0; s0_if.awid = 0; s0_if.awlen = 0; s0_if.awburst = 0;
      s0_if.wvalid = 0; s0_if.wdata = 0; s0_if.wstrb = 0; s0_if.wlast = 0; s0_if.bready = 0;
      s0_if.arvalid = 0; s0_if.araddr = 0; s0_if.arid = 0; s0_if.arlen = 0; s0_if.arburst = 0;
      s0_if.rready = 0;
      s1_if.awvalid = 0; s1_if.awaddr = 0; s1_if.awid = 0; s1_if.awlen = 0; s1_if.awburst = 0;
      s1_if.wvalid = 0; s1_if.wdata = 0; s1_if.wstrb = 0; s1_if.wlast = 0; s1_if.bready = 0;
      s1_if.arvalid = 0; s1_if.araddr = 0; s1_if.arid = 0; s1_if.arlen = 0; s1_if.arburst = 0;
      s1_if.rready = 0;
      m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0; m_if.bid = 0;
      m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rid = 0; m_if.rlast = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      s0_if.arvalid = 1; s0_if.araddr = 32'hDEAD_BEEF; s1_if.awvalid = 1; s1_if.awid = 4'hA;
      m_if.rvalid = 1; m_if.rdata = 32'h1234_5678; m_if.bvalid = 1;
      m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
      tick(); tick();
      tests++; if (hs_outs() !== 15'h0) begin fails++; $display("FAIL rst_handshakes got=%h exp=0", hs_outs()); end
      tests++; if (m_if.araddr !== 32'h0) begin fails++; $display("FAIL rst_araddr got=%h exp=0", m_if.araddr); end
      tests++; if (m_if.awid !== 4'h0) begin fails++; $display("FAIL rst_awid got=%h exp=0", m_if.awid); end
      tests++; if (s0_if.rdata !== 32'h0) begin fails++; $display("FAIL rst_s0_rdata got=%h exp=0", s0_if.rdata); end
      clear_inputs();
      rst_n = 1;
      tick();
   endtask

   task automatic test_single_read();
      clear_inputs();
      s0_if.arvalid = 1; s0_if.araddr = 32'h8000_0000; s0_if.arlen = 8'd7; s0_if.arid = 4'h0; s0_if.arburst = 2'b01;
      #1;
      tests++; if (m_if.arvalid !== 1'b0) begin fails++; $display("FAIL rd_ar_early got=%b exp=0", m_if.arvalid); end
      tick();
      tests++; if (m_if.arvalid !== 1'b1) begin fails++; $display("FAIL rd_arvalid got=%b exp=1", m_if.arvalid); end
      tests++; if (m_if.araddr !== 32'h8000_0000) begin fails++; $display("FAIL rd_araddr got=%h exp=80000000", m_if.araddr); end
      tests++; if (m_if.arlen !== 8'd7) begin fails++; $display("FAIL rd_arlen got=%0d exp=7", m_if.arlen); end
      m_if.arready = 1;
      #1;
      tests++; if ({s1_if.arready, s0_if.arready} !== 2'b01) begin fails++; $display("FAIL rd_arready got=%b exp=01", {s1_if.arready, s0_if.arready}); end
      tick();
      s0_if.arvalid = 0; m_if.arready = 0; s0_if.rready = 1; s1_if.rready = 1;
      for (int i = 0; i < 8; i++) begin
         m_if.rvalid = 1; m_if.rdata = 32'hC000_0000 + i; m_if.rid = 4'h0; m_if.rlast = (i == 7);
         #1;
         tests++; if (s0_if.rvalid !== 1'b1) begin fails++; $display("FAIL rd_s0_rvalid beat=%0d got=%b exp=1", i, s0_if.rvalid); end
         tests++; if (s0_if.rdata !== 32'hC000_0000 + i) begin fails++; $display("FAIL rd_s0_rdata beat=%0d got=%h exp=%h", i, s0_if.rdata, 32'hC000_0000 + i); end
         tests++; if (s0_if.rlast !== (i == 7)) begin fails++; $display("FAIL rd_s0_rlast beat=%0d got=%b exp=%b", i, s0_if.rlast, (i == 7)); end
         tests++; if (s1_if.rvalid !== 1'b0) begin fails++; $display("FAIL rd_s1_rvalid beat=%0d got=%b exp=0", i, s1_if.rvalid); end
         tests++; if (m_if.rready !== 1'b1) begin fails++; $display("FAIL rd_m_rready beat=%0d got=%b exp=1", i, m_if.rready); end
         tick();
      end
      #1;
      tests++; if (m_if.rready !== 1'b0) begin fails++; $display("FAIL rd_idle_rready got=%b exp=0", m_if.rready); end
      clear_inputs();
   endtask

   task automatic test_tie();
      logic exp_g [3];
      logic [31:0] exp_addr;
`ifdef RISCV_AXI_ARB_RR_EN
      exp_g = '{1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b1, 1'b1, 1'b1};
`endif
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         s0_if.arvalid = 1; s0_if.araddr = 32'h1000; s1_if.arvalid = 1; s1_if.araddr = 32'h2000;
         tick();
         exp_addr = exp_g[i] ? 32'h2000 : 32'h1000;
         tests++; if (m_if.araddr !== exp_addr) begin fails++; $display("FAIL tie_addr rep=%0d got=%h exp=%h", i, m_if.araddr, exp_addr); end
         m_if.arready = 1;
         #1;
         tests++; if ({s1_if.arready, s0_if.arready} !== (exp_g[i] ? 2'b10 : 2'b01)) begin fails++; $display("FAIL tie_arready rep=%0d got=%b", i, {s1_if.arready, s0_if.arready}); end
         tick();
         s0_if.arvalid = 0; s1_if.arvalid = 0; m_if.arready = 0;
         m_if.rvalid = 1; m_if.rlast = 1; s0_if.rready = 1; s1_if.rready = 1;
         #1;
         tests++; if ({s1_if.rvalid, s0_if.rvalid} !== (exp_g[i] ? 2'b10 : 2'b01)) begin fails++; $display("FAIL tie_rvalid rep=%0d got=%b", i, {s1_if.rvalid, s0_if.rvalid}); end
         tick();
         m_if.rvalid = 0; m_if.rlast = 0;
      end
      clear_inputs();
   endtask

   task automatic test_concurrent();
      clear_inputs();
      m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
      s1_if.awvalid = 1; s1_if.awaddr = 32'h3000; s1_if.awid = 4'h5; s1_if.awlen = 8'd3; s1_if.awburst = 2'b01;
      s1_if.wvalid = 1; s1_if.wdata = 32'hD000_0000; s1_if.wstrb = 4'hF; s1_if.wlast = 0;
      s0_if.arvalid = 1; s0_if.araddr = 32'h4000; s0_if.arid = 4'h2; s0_if.arlen = 8'd3; s0_if.arburst = 2'b01;
      s0_if.rready = 1; s1_if.bready = 1; s0_if.bready = 1;
      tick();
      tests++; if ({m_if.awvalid, m_if.awid} !== {1'b1, 4'h5}) begin fails++; $display("FAIL cc_aw got=%b/%h exp=1/5", m_if.awvalid, m_if.awid); end
      tests++; if ({m_if.arvalid, m_if.arid} !== {1'b1, 4'h2}) begin fails++; $display("FAIL cc_ar got=%b/%h exp=1/2", m_if.arvalid, m_if.arid); end
      tests++; if ({s1_if.wready, s0_if.wready, m_if.wstrb} !== {2'b10, 4'hF}) begin fails++; $display("FAIL cc_w0 got=%b%b/%h exp=10/f", s1_if.wready, s0_if.wready, m_if.wstrb); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         s1_if.awvalid = 0; s0_if.arvalid = 0;
         if (k <= 3) begin
            s1_if.wdata = 32'hD000_0000 + k; s1_if.wlast = (k == 3);
         end else begin
            s1_if.wvalid = 0; s1_if.wlast = 0;
            m_if.bvalid = 1; m_if.bid = 4'h5; m_if.bresp = 2'b00;
         end
         m_if.rvalid = 1; m_if.rdata = 32'hC000_0000 + k - 1; m_if.rid = 4'h2; m_if.rlast = (k == 4);
         #1;
         tests++; if ({s0_if.rvalid, s0_if.rdata} !== {1'b1, 32'hC000_0000 + k - 1}) begin fails++; $display("FAIL cc_r k=%0d got=%b/%h", k, s0_if.rvalid, s0_if.rdata); end
         tests++; if (s1_if.rvalid !== 1'b0) begin fails++; $display("FAIL cc_s1_rvalid k=%0d got=%b exp=0", k, s1_if.rvalid); end
         if (k <= 3) begin
            tests++; if ({s1_if.wready, m_if.wdata} !== {1'b1, 32'hD000_0000 + k}) begin fails++; $display("FAIL cc_w k=%0d got=%b/%h", k, s1_if.wready, m_if.wdata); end
         end else begin
            tests++; if ({s1_if.bvalid, s1_if.bid, s1_if.bresp} !== {1'b1, 4'h5, 2'b00}) begin fails++; $display("FAIL cc_b1 got=%b/%h/%b exp=1/5/00", s1_if.bvalid, s1_if.bid, s1_if.bresp); end
            tests++; if ({s0_if.bvalid, m_if.bready} !== 2'b01) begin fails++; $display("FAIL cc_b0 got=%b%b exp=01", s0_if.bvalid, m_if.bready); end
         end
      end
      tick();
      m_if.rvalid = 0; m_if.rlast = 0; m_if.bvalid = 0;
      #1;
      tests++; if ({m_if.bready, m_if.rready} !== 2'b00) begin fails++; $display("FAIL cc_idle got=%b exp=00", {m_if.bready, m_if.rready}); end
      clear_inputs();
   endtask

   task automatic test_w_before_aw();
      clear_inputs();
      m_if.wready = 1; m_if.awready = 0;
      s0_if.awvalid = 1; s0_if.awaddr = 32'h5000; s0_if.awid = 4'h7; s0_if.awlen = 8'd1;
      s0_if.wvalid = 1; s0_if.wdata = 32'hE000_0000; s0_if.wstrb = 4'hF; s0_if.wlast = 0;
      m_if.bvalid = 1; m_if.bid = 4'h7; s0_if.bready = 1;
      tick();
      tests++; if ({m_if.awvalid, s0_if.wready} !== 2'b11) begin fails++; $display("FAIL wa_start got=%b exp=11", {m_if.awvalid, s0_if.wready}); end
      tick();
      s0_if.wdata = 32'hE000_0001; s0_if.wlast = 1;
      #1;
      tests++; if ({m_if.wlast, s0_if.wready} !== 2'b11) begin fails++; $display("FAIL wa_last got=%b exp=11", {m_if.wlast, s0_if.wready}); end
      tick();
      s0_if.wvalid = 0; s0_if.wlast = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if ({m_if.awvalid, m_if.wvalid, s0_if.bvalid, m_if.bready} !== 4'b1000) begin fails++; $display("FAIL wa_hold cyc=%0d got=%b exp=1000", i, {m_if.awvalid, m_if.wvalid, s0_if.bvalid, m_if.bready}); end
         tick();
      end
      m_if.awready = 1;
      #1;
      tests++; if (s0_if.awready !== 1'b1) begin fails++; $display("FAIL wa_awready got=%b exp=1", s0_if.awready); end
      tick();
      s0_if.awvalid = 0; m_if.awready = 0;
      #1;
      tests++; if ({s0_if.bvalid, s0_if.bid, m_if.bready} !== {1'b1, 4'h7, 1'b1}) begin fails++; $display("FAIL wa_resp got=%b/%h/%b exp=1/7/1", s0_if.bvalid, s0_if.bid, m_if.bready); end
      tick();
      tests++; if (s0_if.bvalid !== 1'b0) begin fails++; $display("FAIL wa_idle got=%b exp=0", s0_if.bvalid); end
      clear_inputs();
   endtask

   task automatic test_err_backpressure();
      int  beat;
      logic rdy;
      clear_inputs();
      s1_if.arvalid = 1; s1_if.araddr = 32'h6000; s1_if.arid = 4'h9; s1_if.arlen = 8'd3; s1_if.arburst = 2'b01;
      tick();
      m_if.arready = 1;
      #1;
      tests++; if (s1_if.arready !== 1'b1) begin fails++; $display("FAIL eb_arready got=%b exp=1", s1_if.arready); end
      tick();
      s1_if.arvalid = 0; m_if.arready = 0;
      beat = 0;
      for (int c = 0; c < 16 && beat < 4; c++) begin
         rdy = (c % 2 == 0);
         m_if.rvalid = 1; m_if.rdata = 32'hA0 + beat; m_if.rresp = 2'b10; m_if.rid = 4'h9;
         m_if.rlast = (beat == 3); s1_if.rready = rdy;
         #1;
         tests++; if ({s1_if.rvalid, s1_if.rdata, s1_if.rresp} !== {1'b1, 32'hA0 + beat, 2'b10}) begin fails++; $display("FAIL eb_r cyc=%0d got=%b/%h/%b", c, s1_if.rvalid, s1_if.rdata, s1_if.rresp); end
         tests++; if (m_if.rready !== rdy) begin fails++; $display("FAIL eb_rready cyc=%0d got=%b exp=%b", c, m_if.rready, rdy); end
         if (rdy) beat++;
         tick();
      end
      m_if.rlast = 0;
      #1;
      tests++; if (s1_if.rvalid !== 1'b0) begin fails++; $display("FAIL eb_dup got=%b exp=0", s1_if.rvalid); end
      clear_inputs();
      m_if.awready = 1; m_if.wready = 1;
      s0_if.awvalid = 1; s0_if.awid = 4'h3; s0_if.awlen = 8'd0;
      s0_if.wvalid = 1; s0_if.wdata = 32'h55; s0_if.wstrb = 4'hF; s0_if.wlast = 1;
      tick();
      tick();
      s0_if.awvalid = 0; s0_if.wvalid = 0; s0_if.wlast = 0;
      m_if.bvalid = 1; m_if.bresp = 2'b11; m_if.bid = 4'h3; s0_if.bready = 0;
      #1;
      tests++; if ({s0_if.bvalid, s0_if.bresp, s0_if.bid, m_if.bready} !== {1'b1, 2'b11, 4'h3, 1'b0}) begin fails++; $display("FAIL eb_b got=%b/%b/%h/%b", s0_if.bvalid, s0_if.bresp, s0_if.bid, m_if.bready); end
      tick();
      s0_if.bready = 1;
      #1;
      tests++; if (m_if.bready !== 1'b1) begin fails++; $display("FAIL eb_bready got=%b exp=1", m_if.bready); end
      tick();
      tests++; if (s0_if.bvalid !== 1'b0) begin fails++; $display("FAIL eb_b_idle got=%b exp=0", s0_if.bvalid); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_burst();
      clear_inputs();
      s0_if.arvalid = 1; s0_if.araddr = 32'h7000; s0_if.arlen = 8'd7;
      s1_if.awvalid = 1; s1_if.awid = 4'h1; m_if.awready = 1;
      tick();
      m_if.arready = 1;
      tick();
      s0_if.arvalid = 0; m_if.arready = 0; s1_if.awvalid = 0; m_if.awready = 0; s0_if.rready = 1;
      for (int b = 0; b < 2; b++) begin
         m_if.rvalid = 1; m_if.rdata = b;
         tick();
      end
      m_if.rvalid = 1; m_if.rdata = 32'h2;
      #1;
      tests++; if (s0_if.rvalid !== 1'b1) begin fails++; $display("FAIL mr_beat3 got=%b exp=1", s0_if.rvalid); end
      rst_n = 0;
      #1;
      tests++; if (hs_outs() !== 15'h0) begin fails++; $display("FAIL mr_async got=%h exp=0", hs_outs()); end
      tests++; if (s0_if.rdata !== 32'h0) begin fails++; $display("FAIL mr_rdata got=%h exp=0", s0_if.rdata); end
      tick();
      rst_n = 1;
      #1;
      tests++; if ({s0_if.rvalid, m_if.rready} !== 2'b00) begin fails++; $display("FAIL mr_rd_idle got=%b exp=00", {s0_if.rvalid, m_if.rready}); end
      clear_inputs();
      s1_if.arvalid = 1; s1_if.araddr = 32'h8000; s0_if.awvalid = 1; s0_if.awid = 4'h6;
      #1;
      tests++; if ({m_if.arvalid, m_if.awvalid} !== 2'b00) begin fails++; $display("FAIL mr_pre got=%b exp=00", {m_if.arvalid, m_if.awvalid}); end
      tick();
      tests++; if ({m_if.arvalid, m_if.araddr} !== {1'b1, 32'h8000}) begin fails++; $display("FAIL mr_new_ar got=%b/%h exp=1/8000", m_if.arvalid, m_if.araddr); end
      tests++; if ({m_if.awvalid, m_if.awid} !== {1'b1, 4'h6}) begin fails++; $display("FAIL mr_new_aw got=%b/%h exp=1/6", m_if.awvalid, m_if.awid); end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_concurrent();
      test_w_before_aw();
      test_err_backpressure();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
